imsic_msi_arbiter: RTL and testbench

Serialises MSI deliveries from several requesters (e.g. the AXI and TileLink MSI slave ports) onto the single `msi_info` / `msi_info_vld` pair consumed by the per-hart IMSIC CSR gates. The gates synchronise `msi_info_vld` and latch `msi_info` on its rising edge. This block therefore:
- round-robin arbitrates incoming requests into a small FIFO;
- drives each entry as a level pulse of guaranteed high and low width, holding `msi_info` stable for the whole pulse.

---
 rtl/imsic_msi_arbiter_if.sv | 22 ++
 rtl/imsic_msi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_imsic_msi_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imsic_msi_arbiter_if.sv
// Requester handshake and gate-side MSI delivery signals of imsic_msi_arbiter.
// master = arbiter side, slave = requester/gate side.
interface imsic_msi_arbiter_if #(
  parameter int NR_REQ         = 2,
  parameter int MSI_INFO_WIDTH = 17
);
  logic [NR_REQ-1:0]                i_req_vld;
  logic [NR_REQ*MSI_INFO_WIDTH-1:0] i_req_info;
  logic [NR_REQ-1:0]                o_req_rdy;
  logic [MSI_INFO_WIDTH-1:0]        o_msi_info;
  logic                             o_msi_info_vld;

  modport master (
    input  i_req_vld, i_req_info,
    output o_req_rdy, o_msi_info, o_msi_info_vld
  );

  modport slave (
    output i_req_vld, i_req_info,
    input  o_req_rdy, o_msi_info, o_msi_info_vld
  );
endinterface

// File: rtl/imsic_msi_arbiter.sv
// Round-robin MSI arbiter: accepted requests queue in a FIFO and replay as fixed-width vld pulses.
// Pulse rises two edges after a request lands on an idle block; o_req_rdy drops while the FIFO is full.
module imsic_msi_arbiter #(
  parameter int NR_REQ         = 2,
  parameter int MSI_INFO_WIDTH = 17,
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYC       = 4,
  parameter int GAP_CYC        = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  imsic_msi_arbiter_if.master          bus,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_cnt,
  output logic                         o_busy
);
  localparam int W       = MSI_INFO_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int SEL_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      info_q, info_d;
  logic              vld_q, vld_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [W-1:0]      mem_q [FIFO_DEPTH];
  logic [W-1:0]      mem_d [FIFO_DEPTH];

  logic [SEL_W-1:0]  grant;
  logic              found;
  logic              any_vld, full, empty, push, pop;
  logic [W-1:0]      push_dat;
  logic [NR_REQ-1:0] req_rdy;

  assign any_vld = |bus.i_req_vld;
  assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = any_vld & ~full;

  // Two passes give the cyclic scan: indices at/after rr_ptr first, then the wrap-around.
  always_comb begin
    grant = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && bus.i_req_vld[i] && (SEL_W'(i) >= rr_ptr_q)) begin
        grant = SEL_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && bus.i_req_vld[i]) begin
        grant = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_rdy  = '0;
    push_dat = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant == SEL_W'(i)) begin
        req_rdy[i] = any_vld & ~full;
        push_dat   = bus.i_req_info[i*W +: W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (grant == SEL_W'(NR_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = push_dat;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // o_msi_info is loaded only when leaving IDLE, so the gates always see a settled word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    info_d  = info_q;
    vld_d   = vld_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          info_d  = mem_q[rptr_q];
          pop     = 1'b1;
          vld_d   = 1'b1;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          vld_d   = 1'b0;
          cnt_d   = CNT_W'(GAP_CYC - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      info_q   <= '0;
      vld_q    <= 1'b0;
      rr_ptr_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      info_q   <= info_d;
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.o_req_rdy      = req_rdy;
  assign bus.o_msi_info     = info_q;
  assign bus.o_msi_info_vld = vld_q;
  assign o_fifo_cnt         = count_q;
  assign o_busy             = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Directed bench for imsic_msi_arbiter: default instance (2 requesters, 4/4 pulse)
// plus an NR_REQ=1, HOLD=3, GAP=5 instance for the parameter corner.
module tb_imsic_msi_arbiter;
  localparam int W = 17;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  imsic_msi_arbiter_if #(.NR_REQ(2), .MSI_INFO_WIDTH(W)) bus ();
  imsic_msi_arbiter_if #(.NR_REQ(1), .MSI_INFO_WIDTH(W)) bus1 ();
  logic [2:0] fifo_cnt, fifo_cnt1;
  logic       busy, busy1;

  imsic_msi_arbiter #(.NR_REQ(2), .MSI_INFO_WIDTH(W), .FIFO_DEPTH(4), .HOLD_CYC(4), .GAP_CYC(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .o_fifo_cnt(fifo_cnt), .o_busy(busy));
  imsic_msi_arbiter #(.NR_REQ(1), .MSI_INFO_WIDTH(W), .FIFO_DEPTH(4), .HOLD_CYC(3), .GAP_CYC(5)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1), .o_fifo_cnt(fifo_cnt1), .o_busy(busy1));

  int total = 0, bad = 0, cyc = 0, stab_err = 0, rdy_err = 0, max_cnt = 0, stall = 0;
  logic [W-1:0] q0[$], q1[$], got[$], got1[$];
  int gnt[$], hi_len[$], lo_len[$], rise_cyc[$], hi1[$], lo1[$];
  logic pv, pv1;
  logic [W-1:0] pi;
  int run, run1;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records payload at each rise, high/low run lengths, and any info change off a rise.
  always @(negedge clk) begin
    if (!rstn) begin
      pv <= 1'b0; pi <= '0; run <= 0;
    end else begin
      if (bus.o_msi_info_vld && !pv) begin
        got.push_back(bus.o_msi_info); lo_len.push_back(run); rise_cyc.push_back(cyc); run <= 1;
      end else if (!bus.o_msi_info_vld && pv) begin
        hi_len.push_back(run); run <= 1;
      end else run <= run + 1;
      if (bus.o_msi_info !== pi && !(bus.o_msi_info_vld && !pv)) stab_err <= stab_err + 1;
      pv <= bus.o_msi_info_vld;
      pi <= bus.o_msi_info;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      pv1 <= 1'b0; run1 <= 0;
    end else begin
      if (bus1.o_msi_info_vld && !pv1) begin
        got1.push_back(bus1.o_msi_info); lo1.push_back(run1); run1 <= 1;
      end else if (!bus1.o_msi_info_vld && pv1) begin
        hi1.push_back(run1); run1 <= 1;
      end else run1 <= run1 + 1;
      pv1 <= bus1.o_msi_info_vld;
    end
  end

  task automatic clear_mon;
    got.delete(); hi_len.delete(); lo_len.delete(); rise_cyc.delete(); gnt.delete();
    rdy_err = 0; max_cnt = 0; stall = 0;
  endtask

  // Presents queue heads on the requesters; call at a negedge. Returns at the negedge after the last transfer.
  task automatic drive_q(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      bus.i_req_vld  = {q1.size() > 0, q0.size() > 0};
      bus.i_req_info = {(q1.size() > 0) ? q1[0] : {W{1'b0}}, (q0.size() > 0) ? q0[0] : {W{1'b0}}};
      #1;
      if (((bus.o_req_rdy != 2'b00) != (fifo_cnt != 3'd4)) || ($countones(bus.o_req_rdy) > 1)) rdy_err++;
      if (bus.o_req_rdy == 2'b00) stall++;
      if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
      if (bus.i_req_vld[0] && bus.o_req_rdy[0]) begin
        gnt.push_back(0); void'(q0.pop_front());
      end else if (bus.i_req_vld[1] && bus.o_req_rdy[1]) begin
        gnt.push_back(1); void'(q1.pop_front());
      end
      @(negedge clk);
      n++;
    end
    bus.i_req_vld = '0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while ((got.size() < n || busy) && k < budget) begin
      @(negedge clk); k++;
    end
  endtask

  task automatic test_reset;
    bus.i_req_vld = '0; bus.i_req_info = '0; bus1.i_req_vld = '0; bus1.i_req_info = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.o_msi_info, bus.o_msi_info_vld, fifo_cnt, busy} !== '0)
      $display("FAIL reset_hold: info=%h vld=%b cnt=%0d busy=%b, want all 0", bus.o_msi_info, bus.o_msi_info_vld, fifo_cnt, busy);
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.o_msi_info, bus.o_msi_info_vld, fifo_cnt, busy, bus.o_req_rdy} !== '0) begin
      bad++;
      $display("FAIL reset_release: info=%h vld=%b cnt=%0d busy=%b rdy=%b, want all 0", bus.o_msi_info, bus.o_msi_info_vld, fifo_cnt, busy, bus.o_req_rdy);
    end
    bus.i_req_vld = 2'b11; bus1.i_req_vld = 1'b1; #1;
    total++;
    if (bus.o_req_rdy !== 2'b01) begin bad++; $display("FAIL reset_rr_ptr: rdy=%b want 01", bus.o_req_rdy); end
    total++;
    if (bus1.o_req_rdy !== 1'b1) begin bad++; $display("FAIL corner_rdy_empty: rdy=%b want 1", bus1.o_req_rdy); end
    bus.i_req_vld = 2'b10; #1;
    total++;
    if (bus.o_req_rdy !== 2'b10) begin bad++; $display("FAIL grant_only_r1: rdy=%b want 10", bus.o_req_rdy); end
    bus.i_req_vld = '0; bus1.i_req_vld = '0;
  endtask

  task automatic test_single;
    int hi = 0, bz = 0;
    clear_mon();
    @(negedge clk);
    bus.i_req_vld = 2'b01; bus.i_req_info = {17'h0, 17'h0A025}; #1;
    total++;
    if (bus.o_req_rdy !== 2'b01) begin bad++; $display("FAIL single_rdy: rdy=%b want 01", bus.o_req_rdy); end
    @(negedge clk);
    bus.i_req_vld = '0;
    total++;
    if (fifo_cnt !== 3'd1 || bus.o_msi_info_vld !== 1'b0) begin
      bad++; $display("FAIL single_edge_e: cnt=%0d vld=%b want cnt=1 vld=0", fifo_cnt, bus.o_msi_info_vld);
    end
    @(negedge clk);
    total++;
    if (bus.o_msi_info !== 17'h0A025 || bus.o_msi_info_vld !== 1'b1 || fifo_cnt !== 3'd0) begin
      bad++; $display("FAIL single_edge_e1: info=%h vld=%b cnt=%0d want 0a025/1/0", bus.o_msi_info, bus.o_msi_info_vld, fifo_cnt);
    end
    repeat (3) begin @(negedge clk); if (bus.o_msi_info_vld === 1'b1) hi++; end
    @(negedge clk);
    total++;
    if (hi != 3 || bus.o_msi_info_vld !== 1'b0) begin
      bad++; $display("FAIL single_hold: high=%0d vld_after=%b want high=4 then 0", hi + 1, bus.o_msi_info_vld);
    end
    repeat (3) begin @(negedge clk); if (busy === 1'b1) bz++; end
    @(negedge clk);
    total++;
    if (bz != 3 || busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: busy_gap=%0d busy=%b want 3 then 0", bz, busy); end
    total++;
    if (got.size() != 1 || hi_len.size() != 1 || hi_len[0] != 4 || bus.o_msi_info !== 17'h0A025 || stab_err != 0) begin
      bad++; $display("FAIL single_summary: pulses=%0d info=%h stab_err=%0d want 1/0a025/0", got.size(), bus.o_msi_info, stab_err);
    end
  endtask

  task automatic test_contention;
    logic [W-1:0] exp_w[4] = '{17'h10001, 17'h10002, 17'h10003, 17'h10004};
    logic [7:0] gv = '0;
    int miss = 0, per = 0;
    clear_mon();
    q0 = {17'h10001, 17'h10003};
    q1 = {17'h10002, 17'h10004};
    rstn = 1'b0;
    bus.i_req_vld = 2'b11; bus.i_req_info = {q1[0], q0[0]};
    @(negedge clk);
    rstn = 1'b1;
    drive_q(20);
    wait_done(4, 80);
    foreach (gnt[i]) gv = {gv[5:0], 2'(gnt[i])};
    total++;
    if (gnt.size() != 4 || gv !== 8'b00_01_00_01) begin bad++; $display("FAIL contention_grants: n=%0d order=%b want 00010001", gnt.size(), gv); end
    for (int i = 0; i < 4; i++) if (i >= got.size() || got[i] !== exp_w[i]) miss++;
    total++;
    if (miss != 0) begin bad++; $display("FAIL contention_payload: %0d wrong of 4, pulses=%0d", miss, got.size()); end
    for (int i = 1; i < rise_cyc.size(); i++) if (rise_cyc[i] - rise_cyc[i-1] != 9 || lo_len[i] != 5) per++;
    foreach (hi_len[i]) if (hi_len[i] != 4) per++;
    total++;
    if (per != 0 || hi_len.size() != 4 || stab_err != 0) begin
      bad++; $display("FAIL contention_timing: bad_periods=%0d highs=%0d stab_err=%0d want 0/4/0", per, hi_len.size(), stab_err);
    end
  endtask

  task automatic test_backpressure;
    int miss = 0;
    clear_mon();
    for (int i = 0; i < 6; i++) q0.push_back(W'(17'h0B000 + i));
    drive_q(60);
    wait_done(6, 100);
    total++;
    if (max_cnt != 4 || stall == 0 || rdy_err != 0 || q0.size() != 0) begin
      bad++; $display("FAIL bp_rdy: max_cnt=%0d stalls=%0d rdy_err=%0d left=%0d want 4/>0/0/0", max_cnt, stall, rdy_err, q0.size());
    end
    for (int i = 0; i < 6; i++) if (i >= got.size() || got[i] !== W'(17'h0B000 + i)) miss++;
    total++;
    if (miss != 0 || got.size() != 6) begin bad++; $display("FAIL bp_order: %0d wrong, pulses=%0d want 0/6", miss, got.size()); end
  endtask

  task automatic test_wrap;
    int miss = 0;
    clear_mon();
    for (int i = 0; i < 10; i++) q0.push_back(W'(17'h1C000 + 3 * i));
    drive_q(120);
    wait_done(10, 150);
    for (int i = 0; i < 10; i++) if (i >= got.size() || got[i] !== W'(17'h1C000 + 3 * i)) miss++;
    total++;
    if (miss != 0 || got.size() != 10 || rdy_err != 0) begin
      bad++; $display("FAIL wrap_order: %0d wrong, pulses=%0d rdy_err=%0d want 0/10/0", miss, got.size(), rdy_err);
    end
  endtask

  task automatic test_reset_mid;
    clear_mon();
    q0 = {17'h0D001, 17'h0D002, 17'h0D003};
    drive_q(10);
    total++;
    if (bus.o_msi_info_vld !== 1'b1 || fifo_cnt !== 3'd2 || bus.o_msi_info !== 17'h0D001) begin
      bad++; $display("FAIL rmid_pre: vld=%b cnt=%0d info=%h want 1/2/0d001", bus.o_msi_info_vld, fifo_cnt, bus.o_msi_info);
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({bus.o_msi_info, bus.o_msi_info_vld, fifo_cnt, busy} !== '0) begin
      bad++; $display("FAIL rmid_async: info=%h vld=%b cnt=%0d busy=%b want all 0", bus.o_msi_info, bus.o_msi_info_vld, fifo_cnt, busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (got.size() != 1 || busy !== 1'b0 || bus.o_msi_info_vld !== 1'b0) begin
      bad++; $display("FAIL rmid_discard: pulses=%0d busy=%b vld=%b want 1/0/0", got.size(), busy, bus.o_msi_info_vld);
    end
    q0 = {17'h1ABCD};
    drive_q(5);
    wait_done(2, 30);
    total++;
    if (got.size() != 2 || got[1] !== 17'h1ABCD) begin bad++; $display("FAIL rmid_new_req: pulses=%0d want 2 ending 1abcd", got.size()); end
  endtask

  task automatic test_param_corner;
    logic [W-1:0] exp1[$];
    int viol = 0, full_seen = 0, k = 0, miss = 0, per = 0, n = 0;
    got1.delete(); hi1.delete(); lo1.delete();
    for (int i = 0; i < 12; i++) begin
      bus1.i_req_vld = 1'b1; bus1.i_req_info = W'(17'h1F000 + k); #1;
      if (bus1.o_req_rdy !== (fifo_cnt1 != 3'd4)) viol++;
      if (fifo_cnt1 == 3'd4) full_seen++;
      if (bus1.o_req_rdy) begin exp1.push_back(bus1.i_req_info); k++; end
      @(negedge clk);
    end
    bus1.i_req_vld = 1'b0;
    total++;
    if (viol != 0 || full_seen == 0) begin bad++; $display("FAIL corner_rdy: viol=%0d full_cycles=%0d want 0/>0", viol, full_seen); end
    while ((got1.size() < exp1.size() || busy1) && n < 120) begin @(negedge clk); n++; end
    foreach (exp1[i]) if (i >= got1.size() || got1[i] !== exp1[i]) miss++;
    total++;
    if (miss != 0 || got1.size() != exp1.size()) begin
      bad++; $display("FAIL corner_order: %0d wrong, pulses=%0d want 0/%0d", miss, got1.size(), exp1.size());
    end
    foreach (hi1[i]) if (hi1[i] != 3) per++;
    for (int i = 1; i < lo1.size(); i++) if (lo1[i] != 6) per++;
    total++;
    if (per != 0 || hi1.size() != exp1.size()) begin
      bad++; $display("FAIL corner_pulse: bad_widths=%0d highs=%0d want 0/%0d (3 high, 6 low)", per, hi1.size(), exp1.size());
    end
  endtask

  initial begin
    bus.i_req_vld = '0; bus.i_req_info = '0;
    bus1.i_req_vld = '0; bus1.i_req_info = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_param_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
